// File: rtl/irq_arbiter.sv
// irq_arbiter: latches rising edges of N_IRQ interrupt lines as pending, picks one
// pending and unmasked line, and holds a request to cop0 until the request is taken
// and the handler returns with eret.
// Optional feature macro: IRQ_ROUND_ROBIN_EN selects round-robin arbitration.
// When the macro is not defined, the lowest pending index wins.
module irq_arbiter #(
  parameter int unsigned N_IRQ       = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned REQ_TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_mask_we,
  input  logic [N_IRQ-1:0] i_mask_data,
  input  logic             i_exc_taken,
  input  logic             i_eret,
  output logic             o_irq_req,
  output logic [ID_W-1:0]  o_irq_id,
  output logic [N_IRQ-1:0] o_pending,
  output logic [N_IRQ-1:0] o_mask,
  output logic             o_busy,
  output logic             o_timeout
);

  localparam int unsigned CNT_W = $clog2(REQ_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  // Edge history is stored as "line was low last cycle". It resets to 0, so a line
  // that is still high when reset is released has to fall before it can pend again.
  logic [N_IRQ-1:0]   low_q;

  logic [N_IRQ-1:0]   rise;
  logic [N_IRQ-1:0]   cand;
  logic [N_IRQ-1:0]   clr;
  logic [N_IRQ-1:0]   pending_next;
  logic [N_IRQ-1:0]   mask_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    id_next;
  logic               req_next;
  logic               busy_next;
  logic               timeout_next;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_next;
  logic               found;
`endif

  assign rise = i_irq & low_q;
  assign cand = o_pending & o_mask;

  // Winner selection among the candidate lines.
  always_comb begin
    win = '0;
`ifdef IRQ_ROUND_ROBIN_EN
    // First look for the lowest candidate above the last grant, then wrap to the lowest overall.
    found = 1'b0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (cand[i] && (ID_W'(i) > ptr)) begin
        win   = ID_W'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
        if (cand[i]) win = ID_W'(i);
      end
    end
`else
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (cand[i]) win = ID_W'(i);
    end
`endif
  end

  // Next-state, request timeout counter and registered output values.
  always_comb begin
    state_next   = state;
    id_next      = o_irq_id;
    cnt_next     = cnt;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (|cand) begin
          state_next = REQ;
          id_next    = win;
          cnt_next   = '0;
        end
      end
      REQ: begin
        if (i_exc_taken) begin
          state_next = SERVICE;
        end else if (cnt == CNT_W'(REQ_TIMEOUT - 1)) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end else if (cnt != '1) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      SERVICE: begin
        if (i_eret) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    req_next  = (state_next == REQ);
    busy_next = (state_next == SERVICE);
  end

  // Pending bookkeeping: the granted line is cleared on acceptance, and a new edge in the same cycle wins.
  always_comb begin
    clr = '0;
    if ((state == REQ) && i_exc_taken) clr[o_irq_id] = 1'b1;
    pending_next = (o_pending & ~clr) | rise;
    mask_next    = i_mask_we ? i_mask_data : o_mask;
`ifdef IRQ_ROUND_ROBIN_EN
    ptr_next = ((state == REQ) && i_exc_taken) ? o_irq_id : ptr;
`endif
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      low_q     <= '0;
      cnt       <= '0;
      o_irq_req <= 1'b0;
      o_irq_id  <= '0;
      o_pending <= '0;
      o_mask    <= '0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr       <= ID_W'(N_IRQ - 1);
`endif
    end else begin
      state     <= state_next;
      low_q     <= ~i_irq;
      cnt       <= cnt_next;
      o_irq_req <= req_next;
      o_irq_id  <= id_next;
      o_pending <= pending_next;
      o_mask    <= mask_next;
      o_busy    <= busy_next;
      o_timeout <= timeout_next;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr       <= ptr_next;
`endif
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed test of irq_arbiter in the default fixed-priority build.
module tb_irq_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_data;
  logic       exc_taken;
  logic       eret;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] mask;
  logic       busy;
  logic       timeout;

  int vectors;
  int miscompares;

  irq_arbiter #(.N_IRQ(4), .ID_W(2), .REQ_TIMEOUT(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_irq       (irq),
    .i_mask_we   (mask_we),
    .i_mask_data (mask_data),
    .i_exc_taken (exc_taken),
    .i_eret      (eret),
    .o_irq_req   (irq_req),
    .o_irq_id    (irq_id),
    .o_pending   (pending),
    .o_mask      (mask),
    .o_busy      (busy),
    .o_timeout   (timeout)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {req, id, pending, mask, busy, timeout} against the expected packing.
  task automatic check(input string tag, input logic e_req, input logic [1:0] e_id,
                       input logic [3:0] e_pend, input logic [3:0] e_mask,
                       input logic e_busy, input logic e_to);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {irq_req, irq_id, pending, mask, busy, timeout};
    exp = {e_req, e_id, e_pend, e_mask, e_busy, e_to};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed req/id/pend/mask/busy/to=%b/%0d/%h/%h/%b/%b expected %b/%0d/%h/%h/%b/%b",
             tag, obs[12], obs[11:10], obs[9:6], obs[5:2], obs[1], obs[0],
             exp[12], exp[11:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    irq       = 4'h0;
    mask_we   = 1'b0;
    mask_data = 4'h0;
    exc_taken = 1'b0;
    eret      = 1'b0;
    tick();
    tick();
    check("reset", 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // 1: single line through the full request/service/eret cycle.
    mask_we = 1'b1; mask_data = 4'hF;
    tick();
    mask_we = 1'b0;
    check("t1_mask", 1'b0, 2'd0, 4'h0, 4'hF, 1'b0, 1'b0);
    irq = 4'h4;
    tick();
    check("t1_pend_e0", 1'b0, 2'd0, 4'h4, 4'hF, 1'b0, 1'b0);
    tick();
    check("t1_req_e1", 1'b1, 2'd2, 4'h4, 4'hF, 1'b0, 1'b0);
    exc_taken = 1'b1;
    tick();
    exc_taken = 1'b0;
    check("t1_service", 1'b0, 2'd2, 4'h0, 4'hF, 1'b1, 1'b0);
    irq = 4'h0;
    tick();
    check("t1_hold_service", 1'b0, 2'd2, 4'h0, 4'hF, 1'b1, 1'b0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("t1_eret_idle", 1'b0, 2'd2, 4'h0, 4'hF, 1'b0, 1'b0);

    // 2: masked line pends but waits for the mask write.
    mask_we = 1'b1; mask_data = 4'h0;
    tick();
    mask_we = 1'b0;
    irq = 4'h2;
    tick();
    check("t2_pend_masked", 1'b0, 2'd2, 4'h2, 4'h0, 1'b0, 1'b0);
    tick();
    check("t2_no_req", 1'b0, 2'd2, 4'h2, 4'h0, 1'b0, 1'b0);
    mask_we = 1'b1; mask_data = 4'h2;
    tick();
    mask_we = 1'b0;
    check("t2_mask_written", 1'b0, 2'd2, 4'h2, 4'h2, 1'b0, 1'b0);
    tick();
    check("t2_req_id1", 1'b1, 2'd1, 4'h2, 4'h2, 1'b0, 1'b0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("t2_eret_ignored_in_req", 1'b1, 2'd1, 4'h2, 4'h2, 1'b0, 1'b0);
    exc_taken = 1'b1;
    tick();
    exc_taken = 1'b0;
    check("t2_service", 1'b0, 2'd1, 4'h0, 4'h2, 1'b1, 1'b0);
    irq = 4'h0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("t2_idle", 1'b0, 2'd1, 4'h0, 4'h2, 1'b0, 1'b0);

    // 3: two lines together, lowest index first, the other after eret.
    mask_we = 1'b1; mask_data = 4'hF;
    tick();
    mask_we = 1'b0;
    irq = 4'hA;
    tick();
    check("t3_pend_both", 1'b0, 2'd1, 4'hA, 4'hF, 1'b0, 1'b0);
    tick();
    check("t3_req_id1", 1'b1, 2'd1, 4'hA, 4'hF, 1'b0, 1'b0);
    exc_taken = 1'b1;
    tick();
    exc_taken = 1'b0;
    check("t3_service_id1", 1'b0, 2'd1, 4'h8, 4'hF, 1'b1, 1'b0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("t3_idle_after_id1", 1'b0, 2'd1, 4'h8, 4'hF, 1'b0, 1'b0);
    tick();
    check("t3_req_id3", 1'b1, 2'd3, 4'h8, 4'hF, 1'b0, 1'b0);
    exc_taken = 1'b1;
    tick();
    exc_taken = 1'b0;
    check("t3_service_id3", 1'b0, 2'd3, 4'h0, 4'hF, 1'b1, 1'b0);
    eret = 1'b1;
    irq  = 4'h0;
    tick();
    eret = 1'b0;
    check("t3_idle", 1'b0, 2'd3, 4'h0, 4'hF, 1'b0, 1'b0);

    // 4: request held without acceptance times out after 16 cycles and re-requests.
    irq = 4'h1;
    tick();
    check("t4_pend", 1'b0, 2'd3, 4'h1, 4'hF, 1'b0, 1'b0);
    tick();
    check("t4_req_start", 1'b1, 2'd0, 4'h1, 4'hF, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("t4_req_hold_%0d", k), 1'b1, 2'd0, 4'h1, 4'hF, 1'b0, 1'b0);
    end
    tick();
    check("t4_timeout_pulse", 1'b0, 2'd0, 4'h1, 4'hF, 1'b0, 1'b1);
    tick();
    check("t4_rerequest", 1'b1, 2'd0, 4'h1, 4'hF, 1'b0, 1'b0);

    // 5: acceptance on the expiry cycle wins over the timeout.
    for (int k = 1; k <= 15; k++) tick();
    check("t5_still_req", 1'b1, 2'd0, 4'h1, 4'hF, 1'b0, 1'b0);
    exc_taken = 1'b1;
    tick();
    exc_taken = 1'b0;
    check("t5_taken_at_expiry", 1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 1'b0);

    // 6: reset during service; a line held high does not re-pend until it toggles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_reset_in_service", 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 1'b0);
    mask_we = 1'b1; mask_data = 4'hF;
    tick();
    mask_we = 1'b0;
    check("t6_high_line_no_pend", 1'b0, 2'd0, 4'h0, 4'hF, 1'b0, 1'b0);
    tick();
    check("t6_still_no_pend", 1'b0, 2'd0, 4'h0, 4'hF, 1'b0, 1'b0);
    irq = 4'h0;
    tick();
    irq = 4'h1;
    tick();
    check("t6_repend_after_toggle", 1'b0, 2'd0, 4'h1, 4'hF, 1'b0, 1'b0);
    tick();
    check("t6_req_after_toggle", 1'b1, 2'd0, 4'h1, 4'hF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
